// File: rtl/alu_logic_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter: opcodes, FSM state encoding, default width.
package alu_logic_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int OP_W      = 2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic slice: AND / OR / NOR / XOR with a zero flag.
module logic_unit
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OP_W
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/alu_logic_arb.sv
// Round-robin arbiter/sequencer sharing one logic_unit between two requesters.
// Optional grant statistics counters are enabled with the ALU_ARB_STATS_EN macro.
module alu_logic_arb
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
`ifdef ALU_ARB_STATS_EN
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
`endif
    output logic             busy
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_vld, grant_id;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_zero_q, rsp_id_q;
    logic [WIDTH-1:0] lu_y;
    logic             lu_zero;

    // Ready is gated by rst_n so both ready outputs read 0 while reset is held.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (rst_n && state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld & ~grant_id;
    assign req1_ready = grant_vld &  grant_id;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d      = ST_EXEC;
                    last_grant_d = grant_id;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (state_q == ST_EXEC) begin
                rsp_data_q <= lu_y;
                rsp_zero_q <= lu_zero;
                rsp_id_q   <= id_q;
            end
        end
    end

    // Operand latch carries no reset: it is only consumed in EXEC after a grant.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            op_q <= grant_id ? req1_op : req0_op;
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            id_q <= grant_id;
        end
    end

    logic_unit #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_logic_unit (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .y    (lu_y),
        .zero (lu_zero)
    );

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (grant_vld) begin
            if (grant_id) cnt1_q <= cnt1_q + 16'd1;
            else          cnt0_q <= cnt0_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_logic_arb.sv
// Directed bench for alu_logic_arb: cycle model of handshake/arbitration plus a response scoreboard.
module tb_alu_logic_arb;
    import alu_logic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [7:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    alu_logic_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic [7:0] data;
        logic       zero;
    } exp_t;

    exp_t q[$];
    int   gid[$];
    int   gcyc[$];
    int   n_chk = 0, n_pass = 0, n_fail = 0;
    int   mstate = 0;
    logic mlast = 1'b1;
    logic hs0 = 1'b0, hs1 = 1'b0;
    int   mcnt0 = 0, mcnt1 = 0;

    function automatic logic [7:0] lu_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic e0, e1;
        exp_t  e;
        e0 = 1'b0;
        e1 = 1'b0;
        if (mstate == 0) begin
            if (req0_valid && req1_valid) begin
                if (mlast) e0 = 1'b1; else e1 = 1'b1;
            end else if (req0_valid) e0 = 1'b1;
            else if (req1_valid) e1 = 1'b1;
        end
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        chk("busy", {31'd0, busy}, {31'd0, mstate != 0});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, mstate == 2});
        if (mstate == 2) begin
            chk("sb_nonempty", q.size(), (q.size() == 0) ? 32'd1 : q.size());
            if (q.size() > 0) begin
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, q[0].id});
                chk("rsp_data", {24'd0, rsp_data}, {24'd0, q[0].data});
                chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, q[0].zero});
            end
        end
        case (mstate)
            0: if (e0 || e1) begin
                e.id   = e1;
                e.data = e1 ? lu_model(req1_op, req1_a, req1_b) : lu_model(req0_op, req0_a, req0_b);
                e.zero = (e.data == 8'h00);
                q.push_back(e);
                gid.push_back(int'(e1));
                gcyc.push_back(cyc);
                mlast  = e1;
                mstate = 1;
                if (e1) begin hs1 = 1'b1; mcnt1++; end
                else    begin hs0 = 1'b1; mcnt0++; end
            end
            1: mstate = 2;
            default: if (rsp_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                mstate = 0;
            end
        endcase
    endtask

    task automatic step();
        hs0 = 1'b0;
        hs1 = 1'b0;
        @(negedge clk);
        if (rst_n) monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic done;
        done = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = id ? hs1 : hs0;
        end
        chk("issue_handshake", {31'd0, done}, 32'd1);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (mstate != 0 || q.size() != 0); i++) step();
        chk("drain_idle", mstate, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_req0_ready"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, "_req1_ready"}, {31'd0, req1_ready}, 32'd0);
`ifdef ALU_ARB_STATS_EN
        chk({tag, "_grant_cnt0"}, {16'd0, grant_cnt0}, 32'd0);
        chk({tag, "_grant_cnt1"}, {16'd0, grant_cnt1}, 32'd0);
`endif
    endtask

    initial begin
        int base;
        logic got0, got1;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // req0 NOR 0xFF,0x4A -> 0x00, zero flag set, id 0
        rsp_ready = 1'b1;
        issue(1'b0, OP_NOR, 8'hFF, 8'h4A);
        drain();

        // req1 XOR 0x55^0xAA -> 0xFF
        issue(1'b1, OP_XOR, 8'h55, 8'hAA);
        drain();

        // Both valid continuously: alternating grants every 3 cycles
        base = gid.size();
        req0_op = OP_OR;  req0_a = 8'h84; req0_b = 8'h40; req0_valid = 1'b1;
        req1_op = OP_AND; req1_a = 8'h88; req1_b = 8'h85; req1_valid = 1'b1;
        repeat (12) step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        chk("contention_grants", gid.size() - base, 32'd4);
        if (gid.size() - base >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("contention_order", gid[base + k], k % 2);
                if (k > 0) chk("contention_interval", gcyc[base + k] - gcyc[base + k - 1], 32'd3);
            end
        end
        chk("contention_expected_or", {24'd0, lu_model(OP_OR, 8'h84, 8'h40)}, 32'hC4);

        // Backpressure: hold RESP for 5 cycles with req1 waiting
        rsp_ready = 1'b0;
        issue(1'b0, OP_AND, 8'h0F, 8'h3C);
        req1_op = OP_XOR; req1_a = 8'h12; req1_b = 8'h12; req1_valid = 1'b1;
        for (int i = 0; i < 10 && mstate != 2; i++) step();
        chk("bp_in_resp", mstate, 32'd2);
        repeat (5) step();
        chk("bp_data_held", {24'd0, rsp_data}, 32'h0C);
        rsp_ready = 1'b1;
        step();
        chk("bp_released_idle", mstate, 32'd0);
        step();
        chk("bp_next_grant_req1", {31'd0, hs1}, 32'd1);
        req1_valid = 1'b0;
        drain();

        // Asynchronous reset in EXEC discards the in-flight op
        req0_op = OP_NOR; req0_a = 8'h00; req0_b = 8'h00; req0_valid = 1'b1;
        got0 = 1'b0;
        for (int i = 0; i < 20 && !got0; i++) begin
            step();
            got0 = hs0;
        end
        chk("rst_exec_handshake", {31'd0, got0}, 32'd1);
        req0_valid = 1'b0;
        chk("rst_exec_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        mstate = 0;
        mlast  = 1'b1;
        q.delete();
        mcnt0 = 0;
        mcnt1 = 0;
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) step();
        req0_op = OP_XOR; req0_a = 8'h3C; req0_b = 8'h0F; req0_valid = 1'b1;
        req1_op = OP_OR;  req1_a = 8'h01; req1_b = 8'h02; req1_valid = 1'b1;
        step();
        got0 = hs0;
        got1 = hs1;
        chk("post_reset_first_grant_req0", {30'd0, got1, got0}, 32'd1);
        req0_valid = 1'b0;
        repeat (3) step();
        req1_valid = 1'b0;
        drain();

`ifdef ALU_ARB_STATS_EN
        chk("stats_cnt0", {16'd0, grant_cnt0}, mcnt0);
        chk("stats_cnt1", {16'd0, grant_cnt1}, mcnt1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
